// File: rtl/el2_exu_mul_noc_initiator_if.sv
// Flit-level NoC node port. "up" carries flits out of a node and "down" carries flits into it.
interface node_port #(
  parameter int FLIT_BITS = 32,
  parameter int ADDR_BITS = 4
);
  logic                 valid;
  logic                 ready;
  logic [FLIT_BITS-1:0] data;
  logic [ADDR_BITS-1:0] dst_addr;
  logic                 last;

  modport up (output valid, output data, output dst_addr, output last, input ready);
  modport down (input valid, input data, input last, output ready);
endinterface

// File: rtl/el2_exu_mul_noc_initiator.sv
// EXU-side initiator for the NoC multiplier node: serializes one request, reassembles the result.
// Optional watchdog on the result wait is enabled by defining EL2_MUL_NOC_TIMEOUT_EN.
module el2_exu_mul_noc_initiator #(
  parameter int                   FLIT_BITS     = 32,
  parameter int                   MUL_P_BITS    = 16,
  parameter int                   ADDR_BITS     = 4,
  parameter logic [ADDR_BITS-1:0] MUL_NODE_ADDR = 4'd2
`ifdef EL2_MUL_NOC_TIMEOUT_EN
  ,
  parameter int                   TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  noc_sr_flush,
  input  logic                  mul_valid,
  input  logic [31:0]           rs1_in,
  input  logic [31:0]           rs2_in,
  input  logic [MUL_P_BITS-1:0] mul_p,
  output logic                  busy,
  output logic                  result_valid,
  output logic [31:0]           result_x,
  output logic                  timeout_err,
  node_port.up                  up,
  node_port.down                down
);
  localparam int PB   = 64 + MUL_P_BITS;
  localparam int N    = (PB + FLIT_BITS - 1) / FLIT_BITS;
  localparam int SR_W = N * FLIT_BITS;
  localparam int R    = (32 + FLIT_BITS - 1) / FLIT_BITS;
  localparam int RB_W = R * FLIT_BITS;
  localparam int CW   = $clog2(N + 1);
  localparam int RCW  = $clog2(R + 1);
  localparam logic [CW-1:0]  TX_LAST = CW'(N - 1);
  localparam logic [RCW-1:0] RX_LAST = RCW'(R - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DISCARD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            up_valid_q, up_valid_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [RCW-1:0]  rcnt_q, rcnt_d;
  logic [RB_W-1:0] rbuf_q, rbuf_d;
  logic [31:0]     result_x_q, result_x_d;
  logic            result_valid_q, result_valid_d;
  logic            down_rdy, up_fire, down_fire, rx_done, wait_to;

`ifdef EL2_MUL_NOC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout_err_q, timeout_err_d;

  assign wait_to = (state_q == WAIT) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on entry to WAIT and on every accepted result flit.
  always_comb begin
    tcnt_d        = '0;
    timeout_err_d = 1'b0;
    if (state_q == WAIT && !down_fire) tcnt_d = tcnt_q + TW'(1);
    if (wait_to && !noc_sr_flush && !down_fire) timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      tcnt_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tcnt_q        <= tcnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wait_to     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign down_rdy  = (state_q == WAIT) || (state_q == DISCARD);
  assign up_fire   = up_valid_q & up.ready;
  assign down_fire = down_rdy & down.valid;
  assign rx_done   = down_fire & (down.last | (rcnt_q == RX_LAST));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    up_valid_d     = up_valid_q;
    sr_d           = sr_q;
    rcnt_d         = rcnt_q;
    rbuf_d         = rbuf_q;
    result_x_d     = result_x_q;
    result_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mul_valid && !noc_sr_flush) begin
          state_d    = SEND;
          sr_d       = SR_W'({rs1_in, rs2_in, mul_p});
          cnt_d      = '0;
          last_d     = (N == 1);
          up_valid_d = 1'b1;
          rcnt_d     = '0;
          rbuf_d     = '0;
        end
      end
      SEND: begin
        if (noc_sr_flush) begin
          state_d    = IDLE;
          up_valid_d = 1'b0;
          last_d     = 1'b0;
        end else if (up_fire) begin
          cnt_d  = cnt_q + CW'(1);
          sr_d   = sr_q >> FLIT_BITS;
          last_d = (cnt_q + CW'(1) == TX_LAST);
          if (last_q) begin
            state_d    = WAIT;
            up_valid_d = 1'b0;
            last_d     = 1'b0;
          end
        end
      end
      WAIT: begin
        // A partially received result cannot be trusted after a flush; only an untouched one drains via DISCARD.
        if (noc_sr_flush) begin
          state_d = (rcnt_q == '0 && !down_fire) ? DISCARD : IDLE;
        end else if (down_fire) begin
          for (int k = 0; k < R; k++) begin
            if (rcnt_q == RCW'(k)) rbuf_d[k*FLIT_BITS +: FLIT_BITS] = down.data;
          end
          rcnt_d = rcnt_q + RCW'(1);
          if (rx_done) begin
            state_d        = IDLE;
            result_x_d     = rbuf_d[31:0];
            result_valid_d = 1'b1;
          end
        end else if (wait_to) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (down_fire) begin
          rcnt_d = rcnt_q + RCW'(1);
          if (rx_done) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      last_q         <= 1'b0;
      up_valid_q     <= 1'b0;
      rcnt_q         <= '0;
      result_x_q     <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_q         <= last_d;
      up_valid_q     <= up_valid_d;
      rcnt_q         <= rcnt_d;
      result_x_q     <= result_x_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q   <= sr_d;
    rbuf_q <= rbuf_d;
  end

  assign up.valid     = up_valid_q;
  assign up.data      = sr_q[FLIT_BITS-1:0];
  assign up.dst_addr  = MUL_NODE_ADDR;
  assign up.last      = last_q;
  assign down.ready   = down_rdy;
  assign busy         = (state_q != IDLE);
  assign result_valid = result_valid_q;
  assign result_x     = result_x_q;
endmodule
